text_lcd_frame_ctrl: RTL and testbench
======================================

// Module: text_lcd_frame_ctrl
// PURPOSE
//  Parametrised HD44780-class character-LCD driver, write-only. After reset it issues the power-on init
//  command list, then streams a ROWS x COLS character frame to the panel, with a DDRAM address command per row.
//  It sits between the register/bus logic that supplies the text frame and the LCD pins.
//  Adds over the fixed 16-char rotator: configurable geometry and timing, an init sequence, row addressing,
//  frame snapshotting, and an optional on-request refresh mode.
// PARAMETERS
//  ROWS       2    display rows, legal 1..4
//  COLS       16   characters per row, legal 1..40
//  T_SETUP    200  LCDCLK cycles with EN low (address/data setup) at start of each transfer, >=1
//  T_EN       1600 LCDCLK cycles with EN high, >=1
//  T_HOLD     200  LCDCLK cycles with EN low after the EN fall (hold / execute time), >=1
//  T_CLEAR    4000 extra idle cycles after the Clear Display (0x01) command
//  CONTINUOUS 1    1: refresh frames back-to-back; 0: refresh only on refresh_req
// PORTS
//  LCDCLK      in   1              clock
//  PRESETn     in   1              asynchronous, active-low reset
//  data        in   8*ROWS*COLS    frame text; char(r,c) = data[8*(ROWS*COLS-r*COLS-c)-1 -: 8]
//  refresh_req in   1              1-cycle request for one frame refresh (used when CONTINUOUS=0)
//  busy        out  1              high while init or a frame is in progress
//  frame_done  out  1              1-cycle pulse after the last transfer of a frame completes
//  LCD_RS      out  1              0 = command, 1 = character data
//  LCD_RW      out  1              always 0 (write only)
//  LCD_EN      out  1              enable strobe
//  LCD_DATA    out  8              bus data
// BEHAVIOUR
//  Reset values: LCD_RS=0, LCD_RW=0, LCD_EN=0, LCD_DATA=0, busy=1, frame_done=0, FSM=INIT, index=0.
//    Reset asserted mid-transfer aborts it immediately; the full init sequence restarts on release.
//  Transfer cycle: T_CYC = T_SETUP+T_EN+T_HOLD cycles, counted by tcnt = 0..T_CYC-1.
//    At tcnt==0 LCD_RS and LCD_DATA load and then hold for the whole transfer.
//    EN=1 exactly for tcnt in [T_SETUP, T_SETUP+T_EN-1]; EN=0 otherwise. EN is registered (no glitches).
//  FSM:
//    INIT: transfers 0x38, 0x0C, 0x06, 0x01 in order, all RS=0 -> CLRWAIT.
//    CLRWAIT: idles T_CLEAR cycles with EN=0 -> IDLE.
//    IDLE: busy=0. Exits to ADDR when CONTINUOUS=1 or a refresh is pending.
//      On exit: snapshot data into an internal frame register and clear pending; row=0.
//    ADDR: one RS=0 transfer of 0x80|off(row), off = {0x00,0x40,0x14,0x54}[row]; col=0 -> CHAR.
//    CHAR: one RS=1 transfer of snapshot char(row,col) per col.
//      After col==COLS-1: if row==ROWS-1 -> DONE, else row+1 -> ADDR.
//    DONE: frame_done=1 for one cycle -> IDLE (CONTINUOUS=1 re-enters ADDR the next cycle).
//  Pending refresh: refresh_req sets a sticky flag in any state. Requests arriving during a frame
//    or during init coalesce into one following refresh. Ignored when CONTINUOUS=1.
//  Changes on data during a frame have no effect until the next snapshot; the displayed frame is never torn.
//  busy=1 in INIT, CLRWAIT, ADDR, CHAR and DONE.
//  Frame length: ROWS*(COLS+1)*T_CYC cycles from the IDLE exit to the frame_done pulse, +-1 cycle.
//  Counter widths: sized by $clog2 of their maximum values; no wrap occurs inside a transfer.
// TESTING (ROWS=2, COLS=16, T_SETUP=2, T_EN=4, T_HOLD=2, T_CLEAR=40; T_CYC=8)
//  Reset release -> RS=0 transfers 0x38, 0x0C, 0x06, 0x01. EN high 4 cycles out of each 8.
//    40 idle cycles follow, then busy falls.
//  CONTINUOUS=1, data = "HELLO WORLD     ","LINE TWO        " -> bus sequence:
//    0x80, 'H'..' ', 0xC0, 'L'..' '.
//    frame_done pulses after 272 cycles; the next 0x80 follows.
//  data changed mid-frame (row 0, col 5) -> the current frame completes with the old text.
//    The next frame carries the new text.
//  CONTINUOUS=0, no refresh_req -> bus idle, EN=0, busy=0 indefinitely.
//    3 refresh_req pulses during a frame -> exactly one further frame.
//  PRESETn pulsed low while EN=1 in CHAR -> EN=0 and all outputs at reset values asynchronously.
//    The init sequence repeats from 0x38.
//  ROWS=4, COLS=20 -> row address commands 0x80, 0xC0, 0x94, 0xD4; 84 transfers per frame.

Source files
------------

// File: rtl/text_lcd_frame_ctrl.sv
// HD44780-class character LCD driver: power-on init, then ROWS x COLS frames
// streamed from a snapshot of the text input, one DDRAM address command per row.
module text_lcd_frame_ctrl #(
    parameter int ROWS       = 2,
    parameter int COLS       = 16,
    parameter int T_SETUP    = 200,
    parameter int T_EN       = 1600,
    parameter int T_HOLD     = 200,
    parameter int T_CLEAR    = 4000,
    parameter int CONTINUOUS = 1
) (
    input  logic                   LCDCLK,
    input  logic                   PRESETn,
    input  logic [8*ROWS*COLS-1:0] data,
    input  logic                   refresh_req,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   LCD_RS,
    output logic                   LCD_RW,
    output logic                   LCD_EN,
    output logic [7:0]             LCD_DATA
);

    localparam int N     = ROWS * COLS;
    localparam int FW    = 8 * N;
    localparam int T_CYC = T_SETUP + T_EN + T_HOLD;
    localparam int TW    = $clog2(T_CYC);
    localparam int CW    = $clog2(T_CLEAR + 2);
    localparam int IW    = $clog2((COLS > 4) ? COLS : 4);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BW    = $clog2(FW);

    typedef enum logic [2:0] {
        S_INIT,
        S_CLRWAIT,
        S_IDLE,
        S_ADDR,
        S_CHAR,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [CW-1:0]   clr_q, clr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [RW-1:0]   row_q, row_d;
    logic            run_q, run_d;
    logic            pend_q, pend_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            rs_q, rs_d;
    logic [7:0]      dat_q, dat_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            last;
    logic            start;
    logic [BW-1:0]   cbase;
    int              k;

    assign last = run_q && (tcnt_q == TW'(T_CYC - 1));

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        clr_d   = clr_q;
        idx_d   = idx_q;
        row_d   = row_q;
        run_d   = run_q;
        pend_d  = pend_q;
        frame_d = frame_q;
        rs_d    = rs_q;
        dat_d   = dat_q;
        start   = 1'b0;
        cbase   = '0;
        k       = 0;

        unique case (state_q)
            S_INIT: begin
                // First cycle after reset has no transfer running yet.
                if (!run_q) begin
                    idx_d = '0;
                    start = 1'b1;
                end else if (last) begin
                    if (idx_q == IW'(3)) begin
                        state_d = S_CLRWAIT;
                        clr_d   = '0;
                        run_d   = 1'b0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                        start = 1'b1;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_CLRWAIT: begin
                if (int'(clr_q) + 1 >= T_CLEAR) begin
                    state_d = S_IDLE;
                end else begin
                    clr_d = clr_q + CW'(1);
                end
            end
            S_IDLE: begin
                if ((CONTINUOUS != 0) || pend_q) begin
                    frame_d = data;
                    pend_d  = 1'b0;
                    row_d   = '0;
                    state_d = S_ADDR;
                    start   = 1'b1;
                end
            end
            S_ADDR: begin
                if (last) begin
                    state_d = S_CHAR;
                    idx_d   = '0;
                    start   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_CHAR: begin
                if (last) begin
                    if (idx_q == IW'(COLS - 1)) begin
                        if (row_q == RW'(ROWS - 1)) begin
                            state_d = S_DONE;
                            run_d   = 1'b0;
                        end else begin
                            row_d   = row_q + RW'(1);
                            state_d = S_ADDR;
                            start   = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                        start = 1'b1;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        if ((CONTINUOUS == 0) && refresh_req) begin
            pend_d = 1'b1;
        end

        // Bus payload is loaded one edge early so it is valid from tcnt 0.
        if (start) begin
            tcnt_d = '0;
            run_d  = 1'b1;
            unique case (state_d)
                S_INIT: begin
                    rs_d = 1'b0;
                    unique case (idx_d[1:0])
                        2'd0:    dat_d = 8'h38;
                        2'd1:    dat_d = 8'h0C;
                        2'd2:    dat_d = 8'h06;
                        default: dat_d = 8'h01;
                    endcase
                end
                S_ADDR: begin
                    rs_d = 1'b0;
                    unique case (2'(row_d))
                        2'd0:    dat_d = 8'h80;
                        2'd1:    dat_d = 8'hC0;
                        2'd2:    dat_d = 8'h94;
                        default: dat_d = 8'hD4;
                    endcase
                end
                default: begin
                    rs_d  = 1'b1;
                    k     = int'(row_d) * COLS + int'(idx_d);
                    cbase = BW'(8 * (N - 1 - k));
                    dat_d = frame_q[cbase +: 8];
                end
            endcase
        end
    end

    always_comb begin
        en_d = run_d
            && (tcnt_d >= TW'(T_SETUP))
            && (tcnt_d <= TW'(T_SETUP + T_EN - 1));
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge LCDCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= S_INIT;
            tcnt_q  <= '0;
            clr_q   <= '0;
            idx_q   <= '0;
            row_q   <= '0;
            run_q   <= 1'b0;
            pend_q  <= 1'b0;
            frame_q <= '0;
            rs_q    <= 1'b0;
            dat_q   <= 8'h00;
            en_q    <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            clr_q   <= clr_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            run_q   <= run_d;
            pend_q  <= pend_d;
            frame_q <= frame_d;
            rs_q    <= rs_d;
            dat_q   <= dat_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign LCD_RS     = rs_q;
    assign LCD_RW     = 1'b0;
    assign LCD_EN     = en_q;
    assign LCD_DATA   = dat_q;

endmodule

// File: tb/tb_text_lcd_frame_ctrl.sv
// Directed bench for text_lcd_frame_ctrl: init, frames, snapshot,
// on-request refresh, 4x20 geometry and asynchronous reset.
module tb_text_lcd_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    logic         a_rst, a_req, a_busy, a_done, a_rs, a_rw, a_en;
    logic [7:0]   a_d;
    logic [255:0] a_data;
    logic         b_rst, b_req, b_busy, b_done, b_rs, b_rw, b_en;
    logic [7:0]   b_d;
    logic [255:0] b_data;
    logic         c_rst, c_req, c_busy, c_done, c_rs, c_rw, c_en;
    logic [7:0]   c_d;
    logic [639:0] c_data;

    logic [8:0] qa[$];
    logic [8:0] qb[$];
    logic [8:0] qc[$];
    logic a_pen, b_pen, c_pen;

    string r0 = "HELLO WORLD     ";
    string r1 = "LINE TWO        ";

    text_lcd_frame_ctrl #(
        .ROWS(2), .COLS(16), .T_SETUP(2), .T_EN(4), .T_HOLD(2),
        .T_CLEAR(40), .CONTINUOUS(1)
    ) u_dut (
        .LCDCLK(clk), .PRESETn(a_rst), .data(a_data), .refresh_req(a_req),
        .busy(a_busy), .frame_done(a_done), .LCD_RS(a_rs), .LCD_RW(a_rw),
        .LCD_EN(a_en), .LCD_DATA(a_d)
    );

    text_lcd_frame_ctrl #(
        .ROWS(2), .COLS(16), .T_SETUP(2), .T_EN(4), .T_HOLD(2),
        .T_CLEAR(40), .CONTINUOUS(0)
    ) u_once (
        .LCDCLK(clk), .PRESETn(b_rst), .data(b_data), .refresh_req(b_req),
        .busy(b_busy), .frame_done(b_done), .LCD_RS(b_rs), .LCD_RW(b_rw),
        .LCD_EN(b_en), .LCD_DATA(b_d)
    );

    text_lcd_frame_ctrl #(
        .ROWS(4), .COLS(20), .T_SETUP(2), .T_EN(4), .T_HOLD(2),
        .T_CLEAR(40), .CONTINUOUS(1)
    ) u_big (
        .LCDCLK(clk), .PRESETn(c_rst), .data(c_data), .refresh_req(c_req),
        .busy(c_busy), .frame_done(c_done), .LCD_RS(c_rs), .LCD_RW(c_rw),
        .LCD_EN(c_en), .LCD_DATA(c_d)
    );

    // Record {RS,DATA} at every EN rising edge.
    always @(negedge clk) begin
        if (!a_rst) a_pen <= 1'b0;
        else begin
            if (a_en && !a_pen) qa.push_back({a_rs, a_d});
            a_pen <= a_en;
        end
        if (!b_rst) b_pen <= 1'b0;
        else begin
            if (b_en && !b_pen) qb.push_back({b_rs, b_d});
            b_pen <= b_en;
        end
        if (!c_rst) c_pen <= 1'b0;
        else begin
            if (c_en && !c_pen) qc.push_back({c_rs, c_d});
            c_pen <= c_en;
        end
    end

    task automatic wait_done(input int which, input int lim,
                             output int n, output bit to);
        logic d;
        n  = 0;
        to = 1'b1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            n++;
            d = (which == 0) ? a_done : (which == 1) ? b_done : c_done;
            if (d) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        a_req = 1'b0; b_req = 1'b0; c_req = 1'b0;
        a_data = {"HELLO WORLD     ", "LINE TWO        "};
        b_data = {"HELLO WORLD     ", "LINE TWO        "};
        c_data = {80{8'h41}};
        repeat (3) @(negedge clk);
        vecs++; if (a_rs !== 1'b0) begin errs++; $display("FAIL rst_rs: got %b want 0", a_rs); end
        vecs++; if (a_rw !== 1'b0) begin errs++; $display("FAIL rst_rw: got %b want 0", a_rw); end
        vecs++; if (a_en !== 1'b0) begin errs++; $display("FAIL rst_en: got %b want 0", a_en); end
        vecs++; if (a_d !== 8'h00) begin errs++; $display("FAIL rst_data: got %h want 00", a_d); end
        vecs++; if (a_busy !== 1'b1) begin errs++; $display("FAIL rst_busy: got %b want 1", a_busy); end
        vecs++; if (a_done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b want 0", a_done); end
    endtask

    task automatic test_init();
        int n, ens;
        qa.delete();
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        n = 0; ens = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (a_en) ens++;
            if (!a_busy) break;
        end
        vecs++; if (n !== 73) begin errs++; $display("FAIL init_len: got %0d want 73", n); end
        vecs++; if (ens !== 16) begin errs++; $display("FAIL init_en: got %0d want 16", ens); end
        vecs++;
        if (qa.size() !== 4) begin
            errs++; $display("FAIL init_count: got %0d want 4", qa.size());
        end else begin
            vecs++; if (qa[0] !== 9'h038) begin errs++; $display("FAIL init0: got %h want 038", qa[0]); end
            vecs++; if (qa[1] !== 9'h00C) begin errs++; $display("FAIL init1: got %h want 00c", qa[1]); end
            vecs++; if (qa[2] !== 9'h006) begin errs++; $display("FAIL init2: got %h want 006", qa[2]); end
            vecs++; if (qa[3] !== 9'h001) begin errs++; $display("FAIL init3: got %h want 001", qa[3]); end
        end
    endtask

    task automatic test_frame();
        int n;
        bit to;
        logic [8:0] exp;
        qa.delete();
        wait_done(0, 400, n, to);
        vecs++; if (n !== 273 || to) begin errs++; $display("FAIL frame_len: got %0d want 273", n); end
        vecs++;
        if (qa.size() !== 34) begin
            errs++; $display("FAIL frame_count: got %0d want 34", qa.size());
        end else begin
            for (int j = 0; j < 34; j++) begin
                if (j == 0) exp = 9'h080;
                else if (j == 17) exp = 9'h0C0;
                else if (j < 17) exp = {1'b1, r0[j-1]};
                else exp = {1'b1, r1[j-18]};
                vecs++;
                if (qa[j] !== exp) begin
                    errs++; $display("FAIL frame_xfer%0d: got %h want %h", j, qa[j], exp);
                end
            end
        end
        qa.delete();
        @(negedge clk);
        vecs++; if (a_done !== 1'b0) begin errs++; $display("FAIL done_width: got %b want 0", a_done); end
        for (int i = 0; i < 20 && qa.size() == 0; i++) @(negedge clk);
        vecs++;
        if (qa.size() == 0 || qa[0] !== 9'h080) begin
            errs++; $display("FAIL next_addr: got %0d entries want 080 first", qa.size());
        end
    endtask

    task automatic test_midframe();
        int n;
        bit to;
        for (int i = 0; i < 40 && qa.size() < 2; i++) @(negedge clk);
        a_data = {"HELLO#WORLD     ", "LINE TWO        "};
        wait_done(0, 400, n, to);
        vecs++;
        if (to || qa.size() < 7 || qa[6] !== 9'h120) begin
            errs++; $display("FAIL snap_old: got %h want 120", (qa.size() > 6) ? qa[6] : 9'h1FF);
        end
        qa.delete();
        wait_done(0, 400, n, to);
        vecs++;
        if (to || qa.size() < 7 || qa[6] !== 9'h123) begin
            errs++; $display("FAIL snap_new: got %h want 123", (qa.size() > 6) ? qa[6] : 9'h1FF);
        end
        vecs++;
        if (qa.size() == 0 || qa[0] !== 9'h080) begin
            errs++; $display("FAIL snap_addr: got %0d entries want 080 first", qa.size());
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit to;
        a_data = {"HELLO WORLD     ", "LINE TWO        "};
        wait_done(0, 400, n, to);
        vecs++; if (n !== 274 || to) begin errs++; $display("FAIL period: got %0d want 274", n); end
    endtask

    task automatic test_oneshot();
        int n, ens, bsy, dones;
        bit to;
        qb.delete();
        ens = 0; bsy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (b_en) ens++;
            if (b_busy) bsy++;
        end
        vecs++; if (ens !== 0) begin errs++; $display("FAIL idle_en: got %0d want 0", ens); end
        vecs++; if (bsy !== 0) begin errs++; $display("FAIL idle_busy: got %0d want 0", bsy); end
        vecs++; if (qb.size() !== 0) begin errs++; $display("FAIL idle_bus: got %0d want 0", qb.size()); end
        b_req = 1'b1; @(negedge clk); b_req = 1'b0;
        wait_done(1, 400, n, to);
        vecs++;
        if (to || qb.size() !== 34 || qb[0] !== 9'h080) begin
            errs++; $display("FAIL req_frame: got %0d want 34", qb.size());
        end
        qb.delete();
        b_req = 1'b1; @(negedge clk); b_req = 1'b0;
        for (int i = 0; i < 60 && qb.size() < 5; i++) @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            repeat (10) @(negedge clk);
            b_req = 1'b1; @(negedge clk); b_req = 1'b0;
        end
        dones = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (b_done) dones++;
        end
        vecs++; if (dones !== 2) begin errs++; $display("FAIL coalesce: got %0d want 2", dones); end
        vecs++; if (qb.size() !== 68) begin errs++; $display("FAIL coalesce_xfers: got %0d want 68", qb.size()); end
        vecs++; if (b_busy !== 1'b0) begin errs++; $display("FAIL req_idle: got %b want 0", b_busy); end
    endtask

    task automatic test_geom();
        int n;
        bit to;
        wait_done(2, 1500, n, to);
        qc.delete();
        wait_done(2, 1500, n, to);
        vecs++;
        if (to || qc.size() !== 84) begin
            errs++; $display("FAIL geom_count: got %0d want 84", qc.size());
        end else begin
            vecs++; if (qc[0] !== 9'h080) begin errs++; $display("FAIL geom_r0: got %h want 080", qc[0]); end
            vecs++; if (qc[21] !== 9'h0C0) begin errs++; $display("FAIL geom_r1: got %h want 0c0", qc[21]); end
            vecs++; if (qc[42] !== 9'h094) begin errs++; $display("FAIL geom_r2: got %h want 094", qc[42]); end
            vecs++; if (qc[63] !== 9'h0D4) begin errs++; $display("FAIL geom_r3: got %h want 0d4", qc[63]); end
            vecs++; if (qc[83] !== 9'h141) begin errs++; $display("FAIL geom_chr: got %h want 141", qc[83]); end
        end
    endtask

    task automatic test_reset_midframe();
        bit hit;
        qa.delete();
        hit = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (qa.size() >= 3 && a_en && qa[qa.size()-1][8]) begin
                hit = 1'b1;
                break;
            end
        end
        vecs++; if (!hit) begin errs++; $display("FAIL find_char_en: got 0 want 1"); end
        #2 a_rst = 1'b0;
        #1;
        vecs++; if (a_en !== 1'b0) begin errs++; $display("FAIL arst_en: got %b want 0", a_en); end
        vecs++; if (a_d !== 8'h00) begin errs++; $display("FAIL arst_data: got %h want 00", a_d); end
        vecs++; if (a_rs !== 1'b0) begin errs++; $display("FAIL arst_rs: got %b want 0", a_rs); end
        vecs++; if (a_busy !== 1'b1) begin errs++; $display("FAIL arst_busy: got %b want 1", a_busy); end
        @(negedge clk);
        qa.delete();
        a_rst = 1'b1;
        for (int i = 0; i < 30 && qa.size() == 0; i++) @(negedge clk);
        vecs++;
        if (qa.size() == 0 || qa[0] !== 9'h038) begin
            errs++; $display("FAIL reinit: got %0d entries want 038 first", qa.size());
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_frame();
        test_midframe();
        test_back_to_back();
        test_oneshot();
        test_geom();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
